// File: rtl/bp_fe_mem_responder.sv
// FE memory-side responder: ITLB translation, one-line fetch buffer and line refill FSM.
// Accepts fetch / ITLB fill / ITLB fence commands and answers each fetch one cycle later.
package bp_fe_mem_pkg;

  localparam int vaddr_width_gp       = 39;
  localparam int paddr_width_gp       = 32;
  localparam int page_offset_width_gp = 12;
  localparam int vtag_width_gp        = vaddr_width_gp - page_offset_width_gp;
  localparam int ptag_width_gp        = paddr_width_gp - page_offset_width_gp;
  localparam int instr_width_gp       = 32;

  localparam logic [1:0] priv_u_gp = 2'b00;
  localparam logic [1:0] priv_s_gp = 2'b01;
  localparam logic [1:0] priv_m_gp = 2'b11;

  typedef enum logic [1:0] {
    e_op_fetch     = 2'd0,
    e_op_tlb_fill  = 2'd1,
    e_op_tlb_fence = 2'd2
  } bp_fe_mem_op_e;

  typedef struct packed {
    logic [ptag_width_gp-1:0] ptag;
    logic                     u;
    logic                     x;
  } bp_fe_pte_entry_s;

  typedef struct packed {
    logic [vtag_width_gp-1:0] vtag;
    bp_fe_pte_entry_s         entry;
  } bp_fe_fill_operands_s;

  localparam int operand_width_gp = $bits(bp_fe_fill_operands_s);

  typedef struct packed {
    logic [operand_width_gp-vaddr_width_gp-1:0] pad;
    logic [vaddr_width_gp-1:0]                  vaddr;
  } bp_fe_fetch_operands_s;

  typedef union packed {
    bp_fe_fetch_operands_s fetch;
    bp_fe_fill_operands_s  fill;
  } bp_fe_operands_u;

  typedef struct packed {
    bp_fe_mem_op_e   op;
    bp_fe_operands_u operands;
  } bp_fe_mem_cmd_s;

  typedef struct packed {
    logic [instr_width_gp-1:0] data;
    logic                      itlb_miss;
    logic                      instr_page_fault;
    logic                      instr_access_fault;
    logic                      icache_miss;
  } bp_fe_mem_resp_s;

  localparam int mem_cmd_width_gp  = $bits(bp_fe_mem_cmd_s);
  localparam int mem_resp_width_gp = $bits(bp_fe_mem_resp_s);

endpackage

module bp_fe_mem_responder
  import bp_fe_mem_pkg::*;
#(
  parameter int                        itlb_els_p   = 4,
  parameter int                        line_width_p = 512,
  parameter logic [paddr_width_gp-1:0] fetch_base_p = 32'h8000_0000
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [mem_cmd_width_gp-1:0]  mem_cmd_i,
  input  logic                         mem_cmd_v_i,
  output logic                         mem_cmd_yumi_o,
  input  logic [1:0]                   mem_priv_i,
  input  logic                         mem_translation_en_i,
  input  logic                         mem_poison_i,
  output logic [mem_resp_width_gp-1:0] mem_resp_o,
  output logic                         mem_resp_v_o,
  output logic [paddr_width_gp-1:0]    fill_req_addr_o,
  output logic                         fill_req_v_o,
  input  logic                         fill_req_ready_i,
  input  logic [line_width_p-1:0]      fill_data_i,
  input  logic                         fill_data_v_i
);

  localparam int line_offset_lp    = $clog2(line_width_p / 8);
  localparam int line_tag_width_lp = paddr_width_gp - line_offset_lp;
  localparam int ptr_width_lp      = (itlb_els_p > 1) ? $clog2(itlb_els_p) : 1;

  typedef enum logic [1:0] {e_ready, e_req, e_wait} state_e;

  state_e state_r, state_n;

  bp_fe_mem_cmd_s       mem_cmd;
  bp_fe_fill_operands_s fill_op;
  logic [vaddr_width_gp-1:0] fetch_vaddr;
  logic [vtag_width_gp-1:0]  fetch_vtag;

  assign mem_cmd     = bp_fe_mem_cmd_s'(mem_cmd_i);
  assign fill_op     = mem_cmd.operands.fill;
  assign fetch_vaddr = mem_cmd.operands.fetch.vaddr;
  assign fetch_vtag  = fetch_vaddr[vaddr_width_gp-1:page_offset_width_gp];

  logic fetch_yumi, fill_yumi, fence_yumi;
  assign fetch_yumi = ~reset_i & mem_cmd_v_i & (mem_cmd.op == e_op_fetch) & (state_r == e_ready);
  assign fill_yumi  = ~reset_i & mem_cmd_v_i & (mem_cmd.op == e_op_tlb_fill);
  assign fence_yumi = ~reset_i & mem_cmd_v_i & (mem_cmd.op == e_op_tlb_fence);
  assign mem_cmd_yumi_o = fetch_yumi | fill_yumi | fence_yumi;

  // ITLB: valids and round-robin pointer are reset, tag/entry storage is not
  logic [itlb_els_p-1:0]    tlb_v_r;
  logic [vtag_width_gp-1:0] tlb_vtag_r  [itlb_els_p];
  bp_fe_pte_entry_s         tlb_entry_r [itlb_els_p];
  logic [ptr_width_lp-1:0]  rr_ptr_r, fill_idx, wr_idx;
  logic                     cam_hit, fill_present;
  bp_fe_pte_entry_s         cam_entry;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cam_hit      = 1'b0;
    cam_entry    = '0;
    fill_present = 1'b0;
    fill_idx     = '0;
    for (int i = 0; i < itlb_els_p; i++) begin
      if (tlb_v_r[i] && (tlb_vtag_r[i] == fetch_vtag)) begin
        cam_hit   = 1'b1;
        cam_entry = tlb_entry_r[i];
      end
      if (tlb_v_r[i] && (tlb_vtag_r[i] == fill_op.vtag)) begin
        fill_present = 1'b1;
        fill_idx     = ptr_width_lp'(i);
      end
    end
  end

  assign wr_idx = fill_present ? fill_idx : rr_ptr_r;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tlb_v_r  <= '0;
      rr_ptr_r <= '0;
    end else if (fence_yumi) begin
      tlb_v_r <= '0;
    end else if (fill_yumi) begin
      tlb_v_r[wr_idx] <= 1'b1;
      if (!fill_present)
        rr_ptr_r <= (rr_ptr_r == ptr_width_lp'(itlb_els_p - 1)) ? '0 : rr_ptr_r + 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset; their valid bits alone decide whether contents are used.
  always_ff @(posedge clk_i) begin
    if (fill_yumi) begin
      tlb_vtag_r[wr_idx]  <= fill_op.vtag;
      tlb_entry_r[wr_idx] <= fill_op.entry;
    end
  end

  // Stage 1: the fetch as it looked in the cycle it was accepted
  logic                      s1_v_r;
  logic [paddr_width_gp-1:0] s1_paddr_r;
  logic                      s1_trans_r, s1_hit_r, s1_u_r, s1_x_r;
  logic [1:0]                s1_priv_r;
  logic [paddr_width_gp-1:0] fetch_paddr;

  assign fetch_paddr = mem_translation_en_i
                     ? {cam_entry.ptag, fetch_vaddr[page_offset_width_gp-1:0]}
                     : fetch_vaddr[paddr_width_gp-1:0];

  logic [line_width_p-1:0]      line_r;
  logic [line_tag_width_lp-1:0] line_tag_r, fill_tag_r;
  logic                         line_v_r, line_we;

  bp_fe_mem_resp_s resp;
  logic            page_fault, line_hit, start_fill;

  assign page_fault = s1_hit_r & (~s1_x_r | ((s1_priv_r == priv_u_gp) & ~s1_u_r)
                                          | ((s1_priv_r == priv_s_gp) &  s1_u_r));
  assign line_hit   = line_v_r & (line_tag_r == s1_paddr_r[paddr_width_gp-1:line_offset_lp]);

  always_comb begin
    resp = '0;
    if (s1_trans_r && !s1_hit_r)           resp.itlb_miss          = 1'b1;
    else if (page_fault)                   resp.instr_page_fault   = 1'b1;
    else if (s1_paddr_r < fetch_base_p)    resp.instr_access_fault = 1'b1;
    else if (!line_hit)                    resp.icache_miss        = 1'b1;
    else resp.data = line_r[{s1_paddr_r[line_offset_lp-1:2], 5'd0} +: instr_width_gp];
  end

  assign mem_resp_o   = s1_v_r ? resp : '0;
  assign mem_resp_v_o = s1_v_r & ~mem_poison_i;
  assign start_fill   = mem_resp_v_o & resp.icache_miss & (state_r == e_ready);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) s1_v_r <= 1'b0;
    else         s1_v_r <= fetch_yumi & ~start_fill;
  end

  always_ff @(posedge clk_i) begin
    if (fetch_yumi) begin
      s1_paddr_r <= fetch_paddr;
      s1_trans_r <= mem_translation_en_i;
      s1_hit_r   <= mem_translation_en_i & cam_hit;
      s1_u_r     <= cam_entry.u;
      s1_x_r     <= cam_entry.x;
      s1_priv_r  <= mem_priv_i;
    end
  end

  always_comb begin
    state_n      = state_r;
    fill_req_v_o = 1'b0;
    line_we      = 1'b0;
    case (state_r)
      e_ready: if (start_fill) state_n = e_req;
      e_req: begin
        fill_req_v_o = 1'b1;
        if (fill_req_ready_i) state_n = e_wait;
      end
      e_wait: if (fill_data_v_i) begin
        line_we = 1'b1;
        state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r  <= e_ready;
      line_v_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if (line_we) line_v_r <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_fill) fill_tag_r <= s1_paddr_r[paddr_width_gp-1:line_offset_lp];
    if (line_we) begin
      line_r     <= fill_data_i;
      line_tag_r <= fill_tag_r;
    end
  end

  assign fill_req_addr_o = {fill_tag_r, {line_offset_lp{1'b0}}};

endmodule

// File: tb/tb_bp_fe_mem_responder.sv
// Self-checking bench for bp_fe_mem_responder: directed scenarios with literal expectations,
// then randomized commands, all compared every cycle against a transaction-level model.
module tb_bp_fe_mem_responder;
  import bp_fe_mem_pkg::*;

  logic clk_i = 1'b0;
  logic reset_i;
  bp_fe_mem_cmd_s cmd;
  logic cmd_v, yumi, trans_en, poison, resp_v;
  logic [1:0] priv;
  logic [mem_resp_width_gp-1:0] resp_raw;
  bp_fe_mem_resp_s resp;
  logic [31:0] fill_addr;
  logic fill_v, fill_ready, fill_data_v;
  logic [511:0] fill_data;

  assign resp = bp_fe_mem_resp_s'(resp_raw);
  always #5 clk_i = ~clk_i;

  bp_fe_mem_responder dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v), .mem_cmd_yumi_o(yumi),
    .mem_priv_i(priv), .mem_translation_en_i(trans_en), .mem_poison_i(poison),
    .mem_resp_o(resp_raw), .mem_resp_v_o(resp_v),
    .fill_req_addr_o(fill_addr), .fill_req_v_o(fill_v), .fill_req_ready_i(fill_ready),
    .fill_data_i(fill_data), .fill_data_v_i(fill_data_v)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    logic [31:0] paddr;
    bit          trans, hit, u, x;
    logic [1:0]  priv;
  } s1_t;

  bit          m_tlb_v [4];
  logic [26:0] m_vtag  [4];
  logic [19:0] m_ptag  [4];
  bit          m_u [4], m_x [4];
  int          m_rr;
  bit          m_line_v;
  logic [25:0] m_line_tag;
  logic [511:0] m_line;
  int          m_phase;      // 0 idle, 1 request outstanding, 2 waiting for data
  logic [31:0] m_fill_addr;
  s1_t         m_s1;
  int          fill_mode;    // 0 auto, 1 hold data, 2 random, 3 stray data beat

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [511:0] make_line(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = mem_word(base + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [3:0] exp_flags();
    bit pf;
    pf = m_s1.hit && (!m_s1.x || (m_s1.priv == 2'b00 && !m_s1.u) || (m_s1.priv == 2'b01 && m_s1.u));
    if (m_s1.trans && !m_s1.hit) return 4'b1000;
    if (pf) return 4'b0100;
    if (m_s1.paddr < 32'h8000_0000) return 4'b0010;
    if (!(m_line_v && m_line_tag == m_s1.paddr[31:6])) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_tlb_v[i] = 0;
    m_rr = 0; m_line_v = 0; m_phase = 0; m_s1.v = 0;
  endtask

  task automatic model_step();
    s1_t n;
    int idx;
    bit start;
    logic [26:0] vt;
    start = m_s1.v && !poison && exp_flags() == 4'b0001 && m_phase == 0;
    n.v = 0;
    if (cmd_v && cmd.op == e_op_fetch && m_phase == 0 && !start) begin
      vt = cmd.operands.fetch.vaddr[38:12];
      idx = -1;
      for (int i = 0; i < 4; i++) if (m_tlb_v[i] && m_vtag[i] == vt) idx = i;
      n.v = 1; n.trans = trans_en; n.priv = priv;
      n.hit = trans_en && idx >= 0;
      n.u = (idx >= 0) ? m_u[idx] : 0;
      n.x = (idx >= 0) ? m_x[idx] : 0;
      n.paddr = !trans_en ? cmd.operands.fetch.vaddr[31:0]
              : {(idx >= 0) ? m_ptag[idx] : 20'h0, cmd.operands.fetch.vaddr[11:0]};
    end
    if (cmd_v && cmd.op == e_op_tlb_fence) begin
      for (int i = 0; i < 4; i++) m_tlb_v[i] = 0;
    end else if (cmd_v && cmd.op == e_op_tlb_fill) begin
      idx = -1;
      for (int i = 0; i < 4; i++) if (m_tlb_v[i] && m_vtag[i] == cmd.operands.fill.vtag) idx = i;
      if (idx < 0) begin idx = m_rr; m_rr = (m_rr + 1) % 4; end
      m_tlb_v[idx] = 1;
      m_vtag[idx] = cmd.operands.fill.vtag;
      m_ptag[idx] = cmd.operands.fill.entry.ptag;
      m_u[idx] = cmd.operands.fill.entry.u;
      m_x[idx] = cmd.operands.fill.entry.x;
    end
    case (m_phase)
      0: if (start) begin m_phase = 1; m_fill_addr = {m_s1.paddr[31:6], 6'b0}; end
      1: if (fill_ready) m_phase = 2;
      default: if (fill_data_v) begin
        m_line = fill_data; m_line_tag = m_fill_addr[31:6]; m_line_v = 1; m_phase = 0;
      end
    endcase
    m_s1 = n;
  endtask

  task automatic compare();
    logic [3:0] f;
    bit e_yumi;
    e_yumi = !reset_i && cmd_v && (cmd.op != e_op_fetch || m_phase == 0);
    check("yumi", yumi, e_yumi);
    check("resp_v", resp_v, m_s1.v && !poison);
    if (m_s1.v && !poison) begin
      f = exp_flags();
      check("resp_flags", {resp.itlb_miss, resp.instr_page_fault, resp.instr_access_fault, resp.icache_miss}, f);
      if (f == 4'b0000) check("resp_data", resp.data, m_line[m_s1.paddr[5:2]*32 +: 32]);
    end
    check("fill_req_v", fill_v, m_phase == 1);
    if (m_phase == 1) check("fill_req_addr", fill_addr, m_fill_addr);
  endtask

  task automatic drive_fill();
    case (fill_mode)
      0: begin fill_ready = 1; fill_data_v = (m_phase == 2); fill_data = make_line(m_fill_addr); end
      1: begin fill_ready = 1; fill_data_v = 0; end
      3: begin fill_ready = 1; fill_data_v = 1; fill_data = make_line(32'h8000_0080); end
      default: begin
        fill_ready  = ($urandom_range(0, 2) != 0);
        fill_data_v = ($urandom_range(0, 3) == 0);
        fill_data   = (m_phase == 2) ? make_line(m_fill_addr) : {16{$urandom()}};
      end
    endcase
  endtask

  task automatic cycle();
    drive_fill();
    @(negedge clk_i);
    compare();
    if (!reset_i) model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_phase != 0 && n < budget) begin cycle(); n++; end
    if (m_phase != 0) check("fill_timeout", 64'(m_phase), 64'd0);
  endtask

  task automatic set_fetch(input logic [38:0] va);
    cmd = '0; cmd.op = e_op_fetch; cmd.operands.fetch.vaddr = va; cmd_v = 1;
  endtask
  task automatic set_fill(input logic [26:0] vt, input logic [19:0] pt, input bit u, input bit x);
    cmd = '0; cmd.op = e_op_tlb_fill;
    cmd.operands.fill.vtag = vt; cmd.operands.fill.entry.ptag = pt;
    cmd.operands.fill.entry.u = u; cmd.operands.fill.entry.x = x; cmd_v = 1;
  endtask
  task automatic set_fence();
    cmd = '0; cmd.op = e_op_tlb_fence; cmd_v = 1;
  endtask
  task automatic set_idle();
    cmd_v = 0;
  endtask

  // fetch, then sample its stage-1 response #1 into the next cycle
  task automatic fetch_resp(input logic [38:0] va);
    set_fetch(va); cycle(); set_idle(); #1;
  endtask

  initial begin
    logic [3:0] pick;
    logic [11:0] off;
    reset_i = 1; cmd = '0; cmd_v = 0; priv = 2'b11; trans_en = 0; poison = 0;
    fill_ready = 0; fill_data_v = 0; fill_data = '0; fill_mode = 0; m_fill_addr = '0;
    model_reset();
    set_fetch(39'h8000_0004);
    #1;
    check("rst_yumi", yumi, 0);
    check("rst_resp_v", resp_v, 0);
    check("rst_fill_v", fill_v, 0);
    check("rst_resp", resp_raw, 0);
    set_idle();
    repeat (3) cycle();
    reset_i = 0;

    // untranslated miss, refill, refetch
    fetch_resp(39'h8000_0004);
    check("t1_resp_v", resp_v, 1);
    check("t1_icache_miss", resp.icache_miss, 1);
    cycle(); #1;
    check("t1_fill_v", fill_v, 1);
    check("t1_fill_addr", fill_addr, 32'h8000_0000);
    wait_idle(20);
    fetch_resp(39'h8000_0004);
    check("t1_data", resp.data, 32'hDA5A_0004);
    check("t1_flags", resp_raw[3:0], 0);

    // translation: miss, fill, hit
    trans_en = 1; priv = 2'b01;
    fetch_resp(39'h1000);
    check("t2_itlb_miss", resp.itlb_miss, 1);
    cycle(); #1;
    check("t2_no_fill", fill_v, 0);
    set_fill(27'h1, 20'h80000, 0, 1); cycle();
    fetch_resp(39'h1004);
    check("t2_data", resp.data, 32'hDA5A_0004);

    // page and access faults
    set_fill(27'h2, 20'h80000, 0, 0); cycle();
    fetch_resp(39'h2008);
    check("t3_pf_nox", resp.instr_page_fault, 1);
    priv = 2'b00;
    fetch_resp(39'h1008);
    check("t3_pf_user", resp.instr_page_fault, 1);
    set_fill(27'h3, 20'h80000, 1, 1); cycle();
    fetch_resp(39'h300C);
    check("t3_user_ok", resp.data, 32'hDA5A_000C);
    priv = 2'b01;
    fetch_resp(39'h3000);
    check("t3_pf_sup_on_u", resp.instr_page_fault, 1);
    trans_en = 0; priv = 2'b11;
    fetch_resp(39'h1000);
    check("t3_af", resp.instr_access_fault, 1);
    fetch_resp(39'h7FFF_FFFC);
    check("t3_af_edge", resp.instr_access_fault, 1);
    fetch_resp(39'h8000_0000);
    check("t3_base_ok", resp.data, 32'hDA5A_0000);

    // poisoned miss starts no fill; killed fetch behind an unpoisoned miss
    set_fetch(39'h8000_0040); cycle();
    poison = 1; set_fetch(39'h8000_0008); #1;
    check("t4_poison_v", resp_v, 0);
    check("t4_yumi", yumi, 1);
    cycle(); poison = 0; set_idle(); #1;
    check("t4_next_data", resp.data, 32'hDA5A_0008);
    check("t4_no_fill", fill_v, 0);
    cycle();
    set_fetch(39'h8000_0040); cycle();
    set_fetch(39'h8000_0008); #1;
    check("t4_kill_yumi", yumi, 1);
    cycle(); #1;
    check("t4_killed", resp_v, 0);
    check("t4_busy_yumi", yumi, 0);
    set_idle();
    wait_idle(20);

    // replacement wrap, present-entry overwrite, fence
    trans_en = 1; priv = 2'b01;
    set_fence(); cycle();
    for (int i = 10; i < 15; i++) begin set_fill(27'(i), 20'h80000, 0, 1); cycle(); end
    fetch_resp({27'd10, 12'h040});
    check("t5_wrap_evict", resp.itlb_miss, 1);
    fetch_resp({27'd11, 12'h044});
    check("t5_hit11", resp.data, 32'hDA5A_0044);
    set_fill(27'd11, 20'h80000, 0, 0); cycle();
    set_fill(27'd15, 20'h80000, 0, 1); cycle();
    fetch_resp({27'd12, 12'h048});
    check("t5_hit12", resp.data, 32'hDA5A_0048);
    fetch_resp({27'd11, 12'h048});
    check("t5_rr_evict11", resp.itlb_miss, 1);
    set_fetch({27'd14, 12'h04C}); cycle(); set_fence(); #1;
    check("t5_pre_fence", resp.data, 32'hDA5A_004C);
    cycle(); set_idle();
    fetch_resp({27'd14, 12'h04C});
    check("t5_fenced", resp.itlb_miss, 1);

    // reset during the data wait
    trans_en = 0; priv = 2'b11; fill_mode = 1;
    fetch_resp(39'h8000_0080);
    cycle(); cycle();
    set_fetch(39'h8000_0000);
    reset_i = 1; #1;
    check("t6_yumi", yumi, 0);
    check("t6_fill_v", fill_v, 0);
    check("t6_resp_v", resp_v, 0);
    model_reset();
    cycle();
    reset_i = 0; set_idle(); fill_mode = 3;
    cycle(); cycle();
    fill_mode = 0;
    fetch_resp(39'h8000_0080);
    check("t6_line_gone", resp.icache_miss, 1);
    wait_idle(20);

    // randomized traffic
    fill_mode = 2;
    for (int n = 0; n < 4000; n++) begin
      pick = 4'($urandom_range(0, 15));
      off = 12'($urandom_range(0, 1) * 64 + $urandom_range(0, 15) * 4);
      priv = (pick[1:0] == 2'b10) ? 2'b11 : pick[1:0];
      poison = ($urandom_range(0, 7) == 0);
      if (pick < 11) begin
        trans_en = ($urandom_range(0, 3) != 0);
        if (trans_en) set_fetch({27'($urandom_range(0, 5)), off});
        else case ($urandom_range(0, 2))
          0: set_fetch({7'h0, 20'h80000, off});
          1: set_fetch({7'h0, 20'h80001, off});
          default: set_fetch(39'h7FFF_FFFC);
        endcase
      end else if (pick < 14) begin
        case ($urandom_range(0, 3))
          0: set_fill(27'($urandom_range(0, 5)), 20'h80000, 1'($urandom), 1'($urandom));
          1: set_fill(27'($urandom_range(0, 5)), 20'h80001, 1'($urandom), 1'($urandom));
          2: set_fill(27'($urandom_range(0, 5)), 20'h00001, 1'($urandom), 1'($urandom));
          default: set_fill(27'($urandom_range(0, 5)), 20'h7FFFF, 1'($urandom), 1'($urandom));
        endcase
      end else if (pick == 14) begin
        if ($urandom_range(0, 3) == 0) set_fence(); else set_idle();
      end else begin
        set_idle();
      end
      cycle();
    end
    set_idle(); poison = 0; fill_mode = 0;
    wait_idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
